// File: rtl/port_bank.sv
// port_bank: CPU-mapped bank of output registers, synchronized input ports,
// change-detect flags with write-1-to-clear status words, interrupt mask
// words, and a level-sensitive change interrupt.
module port_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_PORTS  = 16,
  parameter int BASE_OUT   = 'hE0,
  parameter int BASE_IN    = 'hF0,
  parameter int CTRL_BASE  = 'hD0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            write,
  output logic [DATA_WIDTH-1:0]           data_out,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
  output logic                            irq
);

  // Status/mask word count; flag and mask vectors are padded to whole words.
  localparam int NW = (NUM_PORTS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PW = NUM_PORTS * DATA_WIDTH;
  localparam int FW = NW * DATA_WIDTH;

  logic [PW-1:0]         out_q,   out_d;
  logic [PW-1:0]         sync1_q, sync1_d;
  logic [PW-1:0]         sync2_q, sync2_d;
  logic [PW-1:0]         prev_q,  prev_d;
  logic [FW-1:0]         flags_q, flags_d;
  logic [FW-1:0]         mask_q,  mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [FW-1:0]         chg;
  int                    off_out, off_in, off_ctrl;

  // Offsets of the address into each window; a hit is an offset in range.
  always_comb begin
    off_out  = int'(address) - BASE_OUT;
    off_in   = int'(address) - BASE_IN;
    off_ctrl = int'(address) - CTRL_BASE;
  end

  // Change detect: synchronized value differs from last cycle's value.
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      chg[i] = (sync2_q[i*DATA_WIDTH +: DATA_WIDTH] != prev_q[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Next-state for output registers, synchronizer chain, flags and mask.
  always_comb begin
    out_d   = out_q;
    sync1_d = port_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    flags_d = '0;
    mask_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (write && off_out == i) begin
        out_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
    end
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < DATA_WIDTH; j++) begin
        if (k*DATA_WIDTH + j < NUM_PORTS) begin
          // A new change outranks a simultaneous write-1-to-clear.
          flags_d[k*DATA_WIDTH + j] = chg[k*DATA_WIDTH + j] |
            (flags_q[k*DATA_WIDTH + j] & ~(write && off_ctrl == k && data_in[j]));
          mask_d[k*DATA_WIDTH + j] = (write && off_ctrl == NW + k) ?
            data_in[j] : mask_q[k*DATA_WIDTH + j];
        end
      end
    end
  end

  // Read mux from pre-edge state; unmapped addresses return zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (off_out == i) rdata_d = out_q[i*DATA_WIDTH +: DATA_WIDTH];
      if (off_in == i)  rdata_d = sync2_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < NW; k++) begin
      if (off_ctrl == k)      rdata_d = flags_q[k*DATA_WIDTH +: DATA_WIDTH];
      if (off_ctrl == NW + k) rdata_d = mask_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State registers; reset clears everything including the data path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign port_out = out_q;
  assign data_out = rdata_q;
  assign irq      = |(flags_q & mask_q);

endmodule

// File: tb/tb_port_bank.sv
// Testbench for port_bank at default parameters: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_port_bank;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   address;
  logic [7:0]   data_in;
  logic         write;
  logic [7:0]   data_out;
  logic [127:0] port_in;
  logic [127:0] port_out;
  logic         irq;

  int checks = 0;
  int errors = 0;

  port_bank dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .write    (write),
    .data_out (data_out),
    .port_in  (port_in),
    .port_out (port_out),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  // Behavioural model: hist[0] is the port_in sample taken at the latest
  // edge, hist[1] one edge older (the synchronized value), hist[2] older still.
  logic [127:0] out_m;
  logic [127:0] hist [3];
  logic [15:0]  flags_m;
  logic [15:0]  mask_m;
  logic [7:0]   dout_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    out_m   = '0;
    hist[0] = '0;
    hist[1] = '0;
    hist[2] = '0;
    flags_m = '0;
    mask_m  = '0;
    dout_m  = '0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int o;
    o = int'(a);
    if (o >= 'hE0 && o <= 'hEF) return out_m[(o - 'hE0)*8 +: 8];
    if (o >= 'hF0 && o <= 'hFF) return hist[1][(o - 'hF0)*8 +: 8];
    if (o == 'hD0) return flags_m[7:0];
    if (o == 'hD1) return flags_m[15:8];
    if (o == 'hD2) return mask_m[7:0];
    if (o == 'hD3) return mask_m[15:8];
    return 8'h00;
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_step();
    logic [7:0]  rd;
    logic [15:0] set_v;
    logic [15:0] clr_v;
    int o;
    rd = model_read(address);
    o  = int'(address);
    for (int i = 0; i < 16; i++) set_v[i] = (hist[1][i*8 +: 8] != hist[2][i*8 +: 8]);
    clr_v = '0;
    if (write && o == 'hD0) clr_v[7:0]  = data_in;
    if (write && o == 'hD1) clr_v[15:8] = data_in;
    flags_m = set_v | (flags_m & ~clr_v);
    if (write && o == 'hD2) mask_m[7:0]  = data_in;
    if (write && o == 'hD3) mask_m[15:8] = data_in;
    if (write && o >= 'hE0 && o <= 'hEF) out_m[(o - 'hE0)*8 +: 8] = data_in;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = port_in;
    dout_m  = rd;
  endtask

  task automatic compare();
    chk("port_out", port_out, out_m);
    chk("data_out", {120'd0, data_out}, {120'd0, dout_m});
    chk("irq", {127'd0, irq}, {127'd0, |(flags_m & mask_m)});
  endtask

  // One clock: model advances, DUT takes the edge, outputs sampled at negedge.
  task automatic cyc();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  initial begin
    reset   = 1'b1;
    address = 8'h00;
    data_in = 8'h00;
    write   = 1'b0;
    port_in = '0;
    model_reset();
    #1;
    chk("reset_port_out", port_out, 128'd0);
    chk("reset_data_out", {120'd0, data_out}, 128'd0);
    chk("reset_irq", {127'd0, irq}, 128'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Output register write and one-cycle read latency (read sees pre-write value).
    address = 8'hE3; data_in = 8'hA5; write = 1'b1;
    cyc();
    write = 1'b0;
    chk("out3_after_write", port_out, {32'd0, 8'hA5, 24'd0} << 64 >> 64);
    chk("read_same_cycle_prewrite", {120'd0, data_out}, 128'd0);
    cyc();
    chk("read_e3", {120'd0, data_out}, {120'd0, 8'hA5});

    // Input word 15 through synchronizer, then its flag in status word 1.
    port_in[127:120] = 8'h3C;
    address = 8'hFF;
    cyc();
    cyc();
    chk("read_ff_edge2", {120'd0, data_out}, 128'd0);
    cyc();
    chk("read_ff_edge3", {120'd0, data_out}, {120'd0, 8'h3C});
    address = 8'hD1;
    cyc();
    chk("read_d1_flag15", {120'd0, data_out}, {120'd0, 8'h80});
    chk("irq_masked", {127'd0, irq}, 128'd0);
    data_in = 8'h80; write = 1'b1;
    cyc();
    write = 1'b0;
    cyc();
    chk("flag15_cleared", {120'd0, data_out}, 128'd0);

    // Unmask port 0, change it, watch irq rise at edge 3 and fall on clear.
    address = 8'hD2; data_in = 8'h01; write = 1'b1;
    cyc();
    write = 1'b0;
    address = 8'h00;
    port_in[7:0] = 8'h11;
    cyc();
    cyc();
    chk("irq_edge2", {127'd0, irq}, 128'd0);
    cyc();
    chk("irq_edge3", {127'd0, irq}, 128'd1);
    address = 8'hD0; data_in = 8'h01; write = 1'b1;
    cyc();
    write = 1'b0;
    chk("irq_cleared", {127'd0, irq}, 128'd0);
    // Change again and clear at the very edge the flag sets: set wins.
    port_in[7:0] = 8'h22;
    cyc();
    cyc();
    write = 1'b1;
    cyc();
    write = 1'b0;
    chk("set_beats_clear", {127'd0, irq}, 128'd1);
    cyc();
    chk("flag0_read", {120'd0, data_out}, {120'd0, 8'h01});

    // Writes to the input window have no effect; unmapped reads return 0.
    address = 8'hF0; data_in = 8'hFF; write = 1'b1;
    cyc();
    write = 1'b0;
    chk("input_write_ignored", port_out, {64'd0, 32'd0, 8'hA5, 24'd0});
    address = 8'h00;
    cyc();
    chk("read_00", {120'd0, data_out}, 128'd0);
    address = 8'hC0;
    cyc();
    chk("read_c0", {120'd0, data_out}, 128'd0);

    // Asynchronous reset between edges with state nonzero.
    #2;
    reset   = 1'b1;
    port_in = '0;
    #1;
    model_reset();
    chk("async_port_out", port_out, 128'd0);
    chk("async_data_out", {120'd0, data_out}, 128'd0);
    chk("async_irq", {127'd0, irq}, 128'd0);
    @(negedge clock);
    reset = 1'b0;
    address = 8'hD2; data_in = 8'hFF; write = 1'b1;
    cyc();
    write = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("irq_after_reset", {127'd0, irq}, 128'd0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: address = 8'($urandom);
        1: address = 8'hE0 + 8'($urandom_range(0, 15));
        2: address = 8'hF0 + 8'($urandom_range(0, 15));
        default: address = 8'hD0 + 8'($urandom_range(0, 4));
      endcase
      data_in = 8'($urandom);
      write   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 3) begin
        port_in[$urandom_range(0, 15)*8 +: 8] = 8'($urandom);
      end
      cyc();
    end
    write = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_bank.md
PORT_BANK -- requirements
Module: port_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the data bus and of every port.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the address bus.
REQ-003 Parameter NUM_PORTS, default 16, legal range 1..2^(ADDR_WIDTH-2): number of input ports and number of output ports.
REQ-004 Parameters BASE_OUT = 'hE0, BASE_IN = 'hF0, CTRL_BASE = 'hD0 (defaults): start addresses of the output, input and control windows.
REQ-005 Derived constant NW = ceil(NUM_PORTS/DATA_WIDTH): number of status words, and also the number of mask words; the address windows shall not overlap.
REQ-006 clock  in  1: the single clock; all state changes on its rising edge.
REQ-007 reset  in  1: asynchronous, active-high reset.
REQ-008 address  in  ADDR_WIDTH: CPU address.
REQ-009 data_in  in  DATA_WIDTH: CPU write data.
REQ-010 write  in  1: write strobe, qualified on each rising clock edge.
REQ-011 data_out  out  DATA_WIDTH: registered read data.
REQ-012 port_in  in  NUM_PORTS*DATA_WIDTH: flattened external inputs; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 port_out  out  NUM_PORTS*DATA_WIDTH: flattened output registers, same packing as port_in.
REQ-014 irq  out  1: change interrupt, level-sensitive.

Function
REQ-015 A write with address = BASE_OUT+i (i < NUM_PORTS) shall load data_in into output register i at that edge; port_out shall reflect the new value immediately after the edge.
REQ-016 Each port_in word shall pass through a two-flop synchronizer; sync_i denotes the second-stage value.
REQ-017 A read of BASE_IN+i shall return sync_i; a read of BASE_OUT+i shall return output register i.
REQ-018 A read of CTRL_BASE+k (k < NW) shall return status word k, i.e. flags[k*DATA_WIDTH +: DATA_WIDTH]; a read of CTRL_BASE+NW+k shall return mask word k; flag and mask bits at index >= NUM_PORTS shall read 0.
REQ-019 data_out shall be registered every cycle from the current address: one-cycle read latency, independent of write.
REQ-020 Reads of unmapped addresses shall return 0.
REQ-021 Writes to the input window, to unmapped addresses or to flag/mask bits at index >= NUM_PORTS shall have no effect.
REQ-022 A per-port register prev_i shall capture sync_i every cycle; flag i shall be set at the edge where sync_i != prev_i.
REQ-023 A write to status word k shall clear every flag whose corresponding data_in bit is 1 (write-1-to-clear); data_in bits of 0 shall leave their flags unchanged.
REQ-024 If a set and a clear of the same flag occur at the same edge, the set shall win.
REQ-025 A write to mask word k shall load mask bits k*DATA_WIDTH.. from data_in.
REQ-026 irq shall be the OR over (flags AND mask), produced combinationally from the registered flags and mask.
REQ-027 Input change to flag set latency: a port_in change that is stable before edge 1 shall set its flag at edge 3, with irq high after edge 3 when that port is unmasked.
REQ-028 A read and a write to the same register in the same cycle shall return the pre-write value.

Reset
REQ-029 While reset is high, the following shall be held at 0, asynchronously: output registers, port_out, synchronizer stages, prev registers, flags, mask, data_out and irq.
REQ-030 Reset asserted mid-operation shall discard pending flags and return to the REQ-029 state; after release, the first input sampled shall not set a flag if it equals 0.

Verification (default parameters)
REQ-031 Write 'hA5 to 'hE3 -> port_out word 3 = 'hA5 after that edge, all other words 0; read 'hE3 -> data_out = 'hA5 one cycle later.
REQ-032 Drive port_in word 15 = 'h3C -> read 'hFF returns 'h3C from the cycle after edge 2; read of 'hD1 returns 'h80 from after edge 3.
REQ-033 Write 'h01 to 'hD2, then change port_in word 0 -> irq rises after edge 3; write 'h01 to 'hD0 -> irq falls; the same port changing again in the clear cycle -> flag remains set.
REQ-034 Write 'hFF to 'hF0 and read 'h00 and 'hC0 -> no state change, data_out = 0.
REQ-035 Assert reset between clock edges with flags, mask and ports nonzero -> every output reads 0 immediately; after release, irq stays 0 while inputs are held at 0.
